// File: rtl/rlb_pkg.sv
// Shared types and helpers for the read line buffer: FSM states, line entry layout,
// and word extract/byte-merge functions on a 128-bit line.
package rlb_pkg;

  localparam int LINE_BYTES = 16;
  localparam int TAG_W      = 28;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [127:0]     data;
  } entry_t;

  function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] sel);
    return line[{sel, 5'b0} +: 32];
  endfunction

  function automatic logic [127:0] merge_word(input logic [127:0] line, input logic [1:0] sel,
                                              input logic [31:0] wdata, input logic [3:0] strb);
    logic [127:0] r;
    r = line;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[int'(sel) * 32 + b * 8 +: 8] = wdata[b * 8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rlb_tag_match.sv
// Parallel tag compare across all entries; reports the matching entry and the
// lowest-index invalid entry.
module rlb_tag_match
  import rlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]            valid_i,
  input  logic [ENTRIES-1:0][TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]              tag_i,
  output logic                          hit_o,
  output logic [IDX_W-1:0]              hit_idx_o,
  output logic                          free_found_o,
  output logic [IDX_W-1:0]              free_idx_o
);

  // Scanning downward lets the lowest index win without a priority chain flag.
  always_comb begin
    hit_o        = 1'b0;
    hit_idx_o    = '0;
    free_found_o = 1'b0;
    free_idx_o   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_i[i] && (tags_i[i] == tag_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(i);
      end
      if (!valid_i[i]) begin
        free_found_o = 1'b1;
        free_idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/read_line_buf.sv
// Read line buffer: serves 32-bit loads from ENTRIES cached 16-byte lines, one miss
// outstanding, snoop write-update for coherence. Optional macro RLB_STATS_EN adds hit/miss counters.
module read_line_buf
  import rlb_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [31:0]  in_addr,
  output logic         in_ready,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  input  logic         resp_ready,
  output logic         mem_req_valid,
  output logic [31:0]  mem_req_addr,
  input  logic         mem_req_ready,
  input  logic         mem_rsp_valid,
  input  logic [127:0] mem_rsp_data,
  input  logic         snoop_valid,
  input  logic [31:0]  snoop_addr,
  input  logic [31:0]  snoop_wdata,
  input  logic [3:0]   snoop_wstrb,
  input  logic         invalidate,
  output logic         busy
`ifdef RLB_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  state_t             state_q, state_d;
  entry_t             entries_q [ENTRIES];
  entry_t             entries_d [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               drop_fill_q, drop_fill_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [1:0]         miss_word_q, miss_word_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;

  logic [ENTRIES-1:0]            valid_vec;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_vec;
  logic                          ld_hit, snp_hit, free_found, snp_free_found;
  logic [IDX_W-1:0]              ld_hit_idx, snp_hit_idx, free_idx, snp_free_idx;
  logic                          accept, in_miss, snoop_miss_match, fill, allocate;
  logic [IDX_W-1:0]              victim;
  logic                          unused_bits;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      tag_vec[i]   = entries_q[i].tag;
    end
  end

  rlb_tag_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_ld_match (
    .valid_i      (valid_vec),
    .tags_i       (tag_vec),
    .tag_i        (in_addr[31:4]),
    .hit_o        (ld_hit),
    .hit_idx_o    (ld_hit_idx),
    .free_found_o (free_found),
    .free_idx_o   (free_idx)
  );

  rlb_tag_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_snp_match (
    .valid_i      (valid_vec),
    .tags_i       (tag_vec),
    .tag_i        (snoop_addr[31:4]),
    .hit_o        (snp_hit),
    .hit_idx_o    (snp_hit_idx),
    .free_found_o (snp_free_found),
    .free_idx_o   (snp_free_idx)
  );

  assign unused_bits = ^{in_addr[1:0], snoop_addr[1:0], snp_free_found, snp_free_idx};

  assign accept           = in_valid && in_ready;
  assign in_miss          = (state_q == ST_MISS_REQ) || (state_q == ST_MISS_WAIT);
  assign snoop_miss_match = in_miss && snoop_valid && (snoop_addr[31:4] == miss_tag_q);
  assign fill             = (state_q == ST_MISS_WAIT) && mem_rsp_valid;
  // A line snooped or invalidated while in flight may be stale: serve it once, never cache it.
  assign allocate         = fill && !drop_fill_q && !snoop_miss_match && !invalidate;
  assign victim           = free_found ? free_idx : rr_ptr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first; a missing branch would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (accept)        state_d = ld_hit ? ST_RESP : ST_MISS_REQ;
      ST_MISS_REQ:  if (mem_req_ready) state_d = ST_MISS_WAIT;
      ST_MISS_WAIT: if (mem_rsp_valid) state_d = ST_RESP;
      ST_RESP:      if (resp_ready)    state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state_q == ST_IDLE) && !invalidate;
    mem_req_valid = (state_q == ST_MISS_REQ);
    mem_req_addr  = mem_req_valid ? {miss_tag_q, 4'b0} : 32'h0;
    resp_valid    = (state_q == ST_RESP);
    resp_rdata    = resp_rdata_q;
    busy          = (state_q != ST_IDLE);
  end

  // Order matters: snoop update, then fill overwrite of the victim, then invalidate.
  always_comb begin
    entries_d    = entries_q;
    rr_ptr_d     = rr_ptr_q;
    drop_fill_d  = drop_fill_q;
    miss_tag_d   = miss_tag_q;
    miss_word_d  = miss_word_q;
    resp_rdata_d = resp_rdata_q;

    if (accept) begin
      if (ld_hit) begin
        resp_rdata_d = line_word(entries_q[ld_hit_idx].data, in_addr[3:2]);
      end else begin
        miss_tag_d  = in_addr[31:4];
        miss_word_d = in_addr[3:2];
      end
    end

    if (snoop_valid && snp_hit) begin
      entries_d[snp_hit_idx].data =
        merge_word(entries_q[snp_hit_idx].data, snoop_addr[3:2], snoop_wdata, snoop_wstrb);
    end

    if (in_miss && (snoop_miss_match || invalidate)) drop_fill_d = 1'b1;

    if (fill) begin
      resp_rdata_d = line_word(mem_rsp_data, miss_word_q);
      drop_fill_d  = 1'b0;
    end

    if (allocate) begin
      entries_d[victim] = '{valid: 1'b1, tag: miss_tag_q, data: mem_rsp_data};
      if (!free_found) rr_ptr_d = rr_ptr_q + 1'b1;
    end

    if (invalidate) begin
      for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
    end
  end

  // NOTE: only the valid bits matter after reset; tag/data are cleared too just to keep X out of sim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q    <= '{default: '0};
      rr_ptr_q     <= '0;
      drop_fill_q  <= 1'b0;
      miss_tag_q   <= '0;
      miss_word_q  <= '0;
      resp_rdata_q <= '0;
    end else begin
      entries_q    <= entries_d;
      rr_ptr_q     <= rr_ptr_d;
      drop_fill_q  <= drop_fill_d;
      miss_tag_q   <= miss_tag_d;
      miss_word_q  <= miss_word_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

`ifdef RLB_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (accept) begin
      if (ld_hit && (hit_count_q != '1))   hit_count_q  <= hit_count_q + 1'b1;
      if (!ld_hit && (miss_count_q != '1)) miss_count_q <= miss_count_q + 1'b1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_read_line_buf.sv
// Directed self-checking bench for read_line_buf: hits, misses, snoop update,
// eviction order, stale-fill drop, backpressure, invalidate and reset mid-miss.
module tb_read_line_buf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [31:0]  in_addr;
  logic         in_ready;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_ready;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         snoop_valid;
  logic [31:0]  snoop_addr;
  logic [31:0]  snoop_wdata;
  logic [3:0]   snoop_wstrb;
  logic         invalidate;
  logic         busy;
`ifdef RLB_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  read_line_buf #(.ENTRIES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_addr       (in_addr),
    .in_ready      (in_ready),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_ready    (resp_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .snoop_valid   (snoop_valid),
    .snoop_addr    (snoop_addr),
    .snoop_wdata   (snoop_wdata),
    .snoop_wstrb   (snoop_wstrb),
    .invalidate    (invalidate),
    .busy          (busy)
`ifdef RLB_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory image: line 0x100 holds the words 0x11111111..0x44444444, others a tagged pattern.
  function automatic logic [127:0] line_data(input logic [31:0] a);
    logic [31:0] l;
    l = {a[31:4], 4'b0};
    if (l == 32'h100) return {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    return {32'hD0000003 | l, 32'hD0000002 | l, 32'hD0000001 | l, 32'hD0000000 | l};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [127:0] l;
    l = line_data(a);
    return l[{a[3:2], 5'b0} +: 32];
  endfunction

  task automatic clear_inputs();
    in_valid      = 1'b0;
    in_addr       = '0;
    resp_ready    = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    snoop_valid   = 1'b0;
    snoop_addr    = '0;
    snoop_wdata   = '0;
    snoop_wstrb   = '0;
    invalidate    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [31:0] a);
    in_valid = 1'b1;
    in_addr  = a;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] exp_addr);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_valid", 32'(mem_req_valid), 32'd1);
    check("req_addr", mem_req_addr, exp_addr);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
  endtask

  task automatic do_rsp(input logic [31:0] a);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_data(a);
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  task automatic take_resp(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_data"}, resp_rdata, exp);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic exp_miss,
                      input logic [31:0] exp);
    issue(a);
    check({tag, "_miss"}, 32'(mem_req_valid), 32'(exp_miss));
    if (exp_miss) begin
      do_req({a[31:4], 4'b0});
      do_rsp(a);
    end else begin
      check({tag, "_hitlat"}, 32'(resp_valid), 32'd1);
    end
    take_resp(tag, exp);
  endtask

  task automatic snoop(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    snoop_valid = 1'b1;
    snoop_addr  = a;
    snoop_wdata = d;
    snoop_wstrb = s;
    @(posedge clk);
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_req_addr"}, mem_req_addr, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check_idle_outputs("rst");
    invalidate = 1'b1;
    #1;
    check("rst_inv_ready", 32'(in_ready), 32'd0);
    invalidate = 1'b0;
    apply_reset();

    // Cold miss then hit in the same line.
    load("cold", 32'h100, 1'b1, 32'h11111111);
    load("hit108", 32'h108, 1'b0, 32'h33333333);

    // Snoop write-update with partial strobe; a non-matching snoop leaves data alone.
    snoop(32'h104, 32'hAABBCCDD, 4'b0011);
    load("snp104", 32'h104, 1'b0, 32'h2222CCDD);
    snoop(32'h30C, 32'h0BADF00D, 4'b1111);
    load("nosnp", 32'h10C, 1'b0, 32'h44444444);

    // Same-cycle hit-accept and snoop: response is pre-snoop, entry is updated.
    in_valid    = 1'b1;
    in_addr     = 32'h100;
    snoop_valid = 1'b1;
    snoop_addr  = 32'h100;
    snoop_wdata = 32'h55555555;
    snoop_wstrb = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    snoop_valid = 1'b0;
    take_resp("hitsnp", 32'h11111111);
    load("hitsnp2", 32'h100, 1'b0, 32'h55555555);

    // Eviction: fill free entries lowest first, then round-robin from 0.
    apply_reset();
    for (int i = 0; i < 4; i++) load("fill", 32'(i * 16), 1'b1, word_of(32'(i * 16)));
    load("ev040", 32'h044, 1'b1, 32'hD0000041);
    load("ev010", 32'h018, 1'b0, 32'hD0000012);
    load("ev000", 32'h000, 1'b1, 32'hD0000000);
    load("ev020", 32'h02C, 1'b0, 32'hD0000023);
    load("ev010b", 32'h010, 1'b1, 32'hD0000010);

    // Stale fill: snoop during wait, and snoop on the same cycle as the response.
    issue(32'h208);
    do_req(32'h200);
    snoop(32'h204, 32'h12345678, 4'b1111);
    do_rsp(32'h208);
    take_resp("stale", 32'hD0000202);
    load("stale_re", 32'h200, 1'b1, 32'hD0000200);
    issue(32'h300);
    do_req(32'h300);
    snoop_valid = 1'b1;
    snoop_addr  = 32'h300;
    snoop_wdata = 32'hFFFFFFFF;
    snoop_wstrb = 4'b1111;
    do_rsp(32'h300);
    snoop_valid = 1'b0;
    take_resp("stale2", 32'hD0000300);
    load("stale2_re", 32'h300, 1'b1, 32'hD0000300);

    // Backpressure on request and response.
    issue(32'h404);
    for (int i = 0; i < 5; i++) begin
      check("bp_req_valid", 32'(mem_req_valid), 32'd1);
      check("bp_req_addr", mem_req_addr, 32'h400);
      @(negedge clk);
    end
    do_req(32'h400);
    do_rsp(32'h404);
    for (int i = 0; i < 3; i++) begin
      check("bp_resp_data", resp_rdata, 32'hD0000401);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    take_resp("bp", 32'hD0000401);
    load("bp_hit", 32'h400, 1'b0, 32'hD0000400);

    // Invalidate drops everything; invalidate during a miss prevents allocation.
    invalidate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    invalidate = 1'b0;
    load("inv400", 32'h400, 1'b1, 32'hD0000400);
    load("inv300", 32'h300, 1'b1, 32'hD0000300);
    issue(32'h500);
    do_req(32'h500);
    invalidate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    invalidate = 1'b0;
    do_rsp(32'h500);
    take_resp("invmiss", 32'hD0000500);
    load("invmiss_re", 32'h500, 1'b1, 32'hD0000500);

    // Reset while waiting for a fill; a late response must be ignored.
    issue(32'h600);
    do_req(32'h600);
    check("mw_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mwrst");
    @(negedge clk);
    rst_n = 1'b1;
    do_rsp(32'h600);
    check("late_resp_valid", 32'(resp_valid), 32'd0);
    check("late_busy", 32'(busy), 32'd0);
    load("after_rst", 32'h608, 1'b1, 32'hD0000602);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_line_buf.md
Name: read_line_buf

Overview:
Read-side counterpart to the compute unit's store merging path. It accepts a 32-bit load stream and serves hits from ENTRIES 16-byte line entries. Misses become 128-bit line reads to memory, one outstanding at a time. It snoops the post-merge 32-bit store stream so that held lines stay coherent with stores already sent to memory.

Parameters:
ENTRIES, 4, number of 16-byte line entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  load request valid
in_addr  input  32  load byte address; [1:0] ignored
in_ready  output  1  load accepted when in_valid&&in_ready
resp_valid  output  1  load data valid
resp_rdata  output  32  load data word
resp_ready  input  1  consumer accepts data
mem_req_valid  output  1  line read request
mem_req_addr  output  32  16-byte aligned line address
mem_req_ready  input  1  memory accepts request
mem_rsp_valid  input  1  line data returned (always accepted)
mem_rsp_data  input  128  line data, word0 at [31:0]
snoop_valid  input  1  store beat observed on the store stream
snoop_addr  input  32  store address
snoop_wdata  input  32  store data
snoop_wstrb  input  4  store byte enables
invalidate  input  1  drop all lines (MEMBAR/abort)
busy  output  1  state!=ST_IDLE

Behaviour:
- Only one clock and one reset: clk, with rst_n as the asynchronous active-low reset.
- Reset values: all entries invalid, state ST_IDLE, rr_ptr=0, drop_fill=0. Outputs after reset: resp_valid=0, resp_rdata=0, mem_req_valid=0, mem_req_addr=0, busy=0, in_ready=1 unless invalidate is high.
- Reset mid-miss: the outstanding fill is abandoned. A later mem_rsp_valid while in ST_IDLE is ignored.
- in_ready = (state==ST_IDLE) && !invalidate.
- At most one load is in flight.
- ST_IDLE, on accept:
  - Hit (valid entry with tag==in_addr[31:4]): latch the word selected by in_addr[3:2] into resp_rdata and go to ST_RESP. resp_valid rises on the cycle after accept (1-cycle hit latency).
  - Miss: latch the line address and go to ST_MISS_REQ.
- ST_MISS_REQ: mem_req_valid=1 with mem_req_addr={tag,4'b0}, held stable until mem_req_ready. On the handshake go to ST_MISS_WAIT.
- ST_MISS_WAIT: on mem_rsp_valid, latch the selected word into resp_rdata and go to ST_RESP. If drop_fill==0, allocate the line. drop_fill clears on leaving ST_MISS_WAIT.
- ST_RESP: resp_valid=1, with resp_rdata held stable until resp_ready, then go to ST_IDLE.
- Allocation victim: the lowest-index invalid entry. If none is invalid, the victim is entries[rr_ptr] and rr_ptr increments (wrapping modulo ENTRIES).
- Snoop is write-update and is valid in any state. For a valid entry whose tag matches snoop_addr[31:4], each byte b with snoop_wstrb[b]=1 is written into word snoop_addr[3:2]. Non-matching snoops are ignored.
- Snoop matching the pending miss line while in ST_MISS_REQ or ST_MISS_WAIT (including the same cycle as mem_rsp_valid): set drop_fill. The fill is returned to the load but not allocated.
- Same-cycle hit-accept and snoop to the same line: the response carries the pre-snoop data, and the entry is updated.
- invalidate clears every valid bit at the next edge, in any state. If asserted in ST_MISS_REQ or ST_MISS_WAIT it also sets drop_fill. An invalidate in the same cycle as a fill prevents that allocation.

Optional Feature:
RLB_STATS_EN
- Defined: adds outputs hit_count[31:0] and miss_count[31:0]. Each counts accepted loads, saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package rlb_pkg: state_t {ST_IDLE, ST_MISS_REQ, ST_MISS_WAIT, ST_RESP}; LINE_BYTES=16; entry_t {valid, tag[31:4], data[127:0]}.
- Sub-module rlb_tag_match: parallel tag compare returning hit/hit_idx and free_found/free_idx. It is instantiated twice, once for the load address and once for the snoop address.

Test Plan:
- Cold miss: load 0x100 -> mem_req_addr=0x100; rsp 128'h4444_3333_2222_1111 -> resp_rdata=0x11111111. A second load 0x108 hits: resp_valid on the cycle after accept, value 0x33333333, no memory request.
- Snoop update: line 0x100 held; snoop addr 0x104, wdata 0xAABBCCDD, wstrb 4'b0011 -> a load of 0x104 returns 0x2222CCDD.
- Eviction: fill lines 0x000, 0x010, 0x020, 0x030, then load 0x040 -> the entry holding 0x000 is replaced (rr_ptr 0->1). A load of 0x000 misses again.
- Stale fill: miss to 0x200; snoop to 0x204 during ST_MISS_WAIT -> the load gets memory data. A load of 0x200 then misses again.
- Backpressure and invalidate: hold mem_req_ready=0 for 5 cycles -> mem_req_addr stays stable. Hold resp_ready=0 -> resp_rdata stays stable and in_ready=0. Invalidate -> all subsequent loads miss.
- Reset in ST_MISS_WAIT: pulse rst_n low -> all outputs return to reset values. A late mem_rsp_valid is ignored, and the next load issues a fresh request.
